// File: rtl/bram_acc_pkg.sv
// Shared definitions for the BRAM accumulate / result-drain blocks.
package bram_acc_pkg;

    // Result-reader FSM state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // BRAM read latency in cycles (ce to q valid)
    localparam int BRAM_RD_LAT = 1;

    // True when one more read may be issued without overrunning the 2-entry FIFO.
    // Occupancy counts words held, words still in flight from BRAM, minus the word
    // leaving the FIFO this cycle.
    function automatic logic credit_ok(input logic [1:0] fifo_cnt,
                                       input logic       inflight,
                                       input logic       pop);
        logic [2:0] occ;
        occ = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
        return (occ < 3'd2);
    endfunction

endpackage

// File: rtl/bram_result_reader_fifo2.sv
// fifo2: two-entry register FIFO; slot0 is always the head, slots beyond the
// current count are kept at zero so the head reads 0 when empty.
module fifo2 #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [1:0]        count_o,
    output logic [DWIDTH-1:0] head_o
);

    logic [DWIDTH-1:0] slot0_q, slot0_d;
    logic [DWIDTH-1:0] slot1_q, slot1_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              pop_s;

    assign pop_s   = pop_i && (cnt_q != 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign count_o = cnt_q;
    assign head_o  = empty_o ? {DWIDTH{1'b0}} : slot0_q;

    // Next slot contents and count for every push/pop combination
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        cnt_d   = cnt_q;
        case ({push_i, pop_s})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    slot0_d = data_i;
                    cnt_d   = 2'd1;
                end else if (cnt_q == 2'd1) begin
                    slot1_d = data_i;
                    cnt_d   = 2'd2;
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            2'b01: begin
                slot0_d = slot1_q;
                slot1_d = {DWIDTH{1'b0}};
                cnt_d   = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    slot0_d = data_i;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = data_i;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Storage registers, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= {DWIDTH{1'b0}};
            slot1_q <= {DWIDTH{1'b0}};
            cnt_q   <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cnt_q   <= cnt_d;
        end
    end

    fifo2_chk u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push_i),
        .full_i (full_o)
    );

endmodule

// File: rtl/fifo2_chk.sv
// Protocol checker for fifo2: a push must never land on a full FIFO.
module fifo2_chk (
    input logic clk,
    input logic rst_n,
    input logic push_i,
    input logic full_i
);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_i));

endmodule

// File: rtl/bram_result_reader.sv
// bram_result_reader: drains BRAM1 rows 0..run_count_i-1 into a valid/ready
// stream, using a 2-entry FIFO and read credits to ride out backpressure.
module bram_result_reader
    import bram_acc_pkg::*;
#(
    parameter int CNT_BIT = 31,
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_run_i,
    input  logic [CNT_BIT-1:0] run_count_i,
    output logic               idle_o,
    output logic               run_o,
    output logic               done_o,
    output logic [AWIDTH-1:0]  addr_b1_o,
    output logic               ce_b1_o,
    output logic               we_b1_o,
    output logic [DWIDTH-1:0]  d_b1_o,
    input  logic [DWIDTH-1:0]  q_b1_i,
    output logic               m_valid_o,
    output logic [DWIDTH-1:0]  m_data_o,
    input  logic               m_ready_i
);

    logic [1:0]         state_q, state_d;
    logic [CNT_BIT-1:0] cnt_q, cnt_d;
    logic [CNT_BIT-1:0] issued_q, issued_d;
    logic [CNT_BIT-1:0] sent_q, sent_d;
    logic               inflight_q;
    logic               pop_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [1:0]         fifo_cnt_s;
    logic [DWIDTH-1:0]  fifo_head_s;

    assign we_b1_o   = 1'b0;
    assign d_b1_o    = {DWIDTH{1'b0}};
    assign m_valid_o = !fifo_empty_s;
    assign m_data_o  = fifo_head_s;
    assign pop_s     = m_valid_o && m_ready_i;
    assign addr_b1_o = issued_q[AWIDTH-1:0];

    // Read data returns one cycle after ce, so the delayed ce is the FIFO push
    fifo2 #(.DWIDTH(DWIDTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (inflight_q),
        .data_i  (q_b1_i),
        .pop_i   (pop_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_cnt_s),
        .head_o  (fifo_head_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; RUN ends on the cycle the final beat leaves (sent_d reaches the count)
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_run_i) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (sent_d == cnt_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: status flags and the read-issue strobe
    always_comb begin
        idle_o  = 1'b0;
        run_o   = 1'b0;
        done_o  = 1'b0;
        ce_b1_o = 1'b0;
        case (state_q)
            S_IDLE: idle_o = 1'b1;
            S_RUN: begin
                run_o   = 1'b1;
                ce_b1_o = (issued_q < cnt_q) && credit_ok(fifo_cnt_s, inflight_q, pop_s);
            end
            S_DONE:  done_o = 1'b1;
            default: idle_o = 1'b0;
        endcase
    end

    // Counter next-state: latch the count and clear progress on start, else advance
    always_comb begin
        cnt_d    = cnt_q;
        issued_d = issued_q + {{(CNT_BIT-1){1'b0}}, ce_b1_o};
        sent_d   = sent_q + {{(CNT_BIT-1){1'b0}}, pop_s};
        if ((state_q == S_IDLE) && start_run_i) begin
            cnt_d    = run_count_i;
            issued_d = {CNT_BIT{1'b0}};
            sent_d   = {CNT_BIT{1'b0}};
        end else begin
            cnt_d    = cnt_q;
        end
    end

    // Count, progress and in-flight registers; reset drops any outstanding read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= {CNT_BIT{1'b0}};
            issued_q   <= {CNT_BIT{1'b0}};
            sent_q     <= {CNT_BIT{1'b0}};
            inflight_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            inflight_q <= ce_b1_o;
        end
    end

endmodule

// File: tb/tb_bram_result_reader.sv
// Self-checking bench for bram_result_reader: a full-size instance plus an
// AWIDTH=2 instance share stimulus; a transaction-level model predicts beats,
// addresses, credit-limited issue and the IDLE/RUN/DONE timeline.
module tb_bram_result_reader;

    localparam int CNT_BIT = 31;
    localparam int DW      = 32;
    localparam int AW      = 8;
    localparam int AW2     = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start_run_i;
    logic [CNT_BIT-1:0] run_count_i;
    logic               m_ready_i;

    logic               idle1, run1, done1, ce1, we1, valid1;
    logic [AW-1:0]      addr1;
    logic [DW-1:0]      d1, q1, data1;
    logic               idle2, run2, done2, ce2, we2, valid2;
    logic [AW2-1:0]     addr2;
    logic [DW-1:0]      d2, q2, data2;

    logic [DW-1:0]      mem1 [256];
    logic [DW-1:0]      mem2 [4];

    int n_checks = 0;
    int n_pass   = 0;

    bram_result_reader #(.CNT_BIT(CNT_BIT), .DWIDTH(DW), .AWIDTH(AW)) u_dut (
        .clk(clk), .reset_n(reset_n), .start_run_i(start_run_i), .run_count_i(run_count_i),
        .idle_o(idle1), .run_o(run1), .done_o(done1), .addr_b1_o(addr1), .ce_b1_o(ce1),
        .we_b1_o(we1), .d_b1_o(d1), .q_b1_i(q1), .m_valid_o(valid1), .m_data_o(data1),
        .m_ready_i(m_ready_i)
    );

    bram_result_reader #(.CNT_BIT(CNT_BIT), .DWIDTH(DW), .AWIDTH(AW2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start_run_i(start_run_i), .run_count_i(run_count_i),
        .idle_o(idle2), .run_o(run2), .done_o(done2), .addr_b1_o(addr2), .ce_b1_o(ce2),
        .we_b1_o(we2), .d_b1_o(d2), .q_b1_i(q2), .m_valid_o(valid2), .m_data_o(data2),
        .m_ready_i(m_ready_i)
    );

    always #5 clk = ~clk;

    // BRAM models with one-cycle read latency
    always @(posedge clk) begin
        if (ce1) q1 <= mem1[addr1];
        if (ce2) q2 <= mem2[addr2];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_idle"},  {63'd0, idle1},  64'd1);
        check_eq({tag, "_run"},   {63'd0, run1},   64'd0);
        check_eq({tag, "_done"},  {63'd0, done1},  64'd0);
        check_eq({tag, "_ce"},    {63'd0, ce1},    64'd0);
        check_eq({tag, "_addr"},  {56'd0, addr1},  64'd0);
        check_eq({tag, "_valid"}, {63'd0, valid1}, 64'd0);
        check_eq({tag, "_data"},  {32'd0, data1},  64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        start_run_i = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // mode: 0 = ready always, 1 = ready pattern 1,0,0, 2 = random ready
    task automatic do_run(input int n, input int mode, input bit hold_start,
                          input int rst_after, input bit chk_lat);
        int issued = 0;
        int accepted = 0;
        int first_valid = -1;
        int last_acc = -1;
        bit finished = 1'b0;
        bit aborted = 1'b0;
        bit pop, exp_run, exp_done, exp_idle, exp_ce;
        bit prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic [DW-1:0] got[$];
        logic [DW-1:0] beats2[$];
        logic [AW2-1:0] addrs2[$];

        @(negedge clk);
        check_eq("pre_idle", {63'd0, idle1}, 64'd1);
        run_count_i = CNT_BIT'(n);
        start_run_i = 1'b1;
        m_ready_i   = 1'b0;
        @(posedge clk);  // E0
        for (int j = 0; !finished; j++) begin
            @(negedge clk);
            if (j == 0 && !hold_start) start_run_i = 1'b0;
            case (mode)
                0:       m_ready_i = 1'b1;
                1:       m_ready_i = ((j % 3) == 0);
                default: m_ready_i = 1'($urandom_range(0, 1));
            endcase
            #1;
            pop      = valid1 && m_ready_i;
            exp_run  = (n == 0) ? (j == 0) : (last_acc < 0);
            exp_done = (n == 0) ? (j == 1) : (last_acc >= 0 && j == last_acc + 1);
            exp_idle = (n == 0) ? (j >= 2) : (last_acc >= 0 && j > last_acc + 1);
            check_eq("run",  {63'd0, run1},  {63'd0, exp_run});
            check_eq("done", {63'd0, done1}, {63'd0, exp_done});
            check_eq("idle", {63'd0, idle1}, {63'd0, exp_idle});
            exp_ce = exp_run && (issued < n) && ((issued - accepted - int'(pop)) < 2);
            check_eq("ce", {63'd0, ce1}, {63'd0, exp_ce});
            if (ce1) begin
                check_eq("addr", {56'd0, addr1}, 64'(issued % 256));
                issued++;
            end
            if (ce2) addrs2.push_back(addr2);
            if (n == 0) check_eq("valid_zero", {63'd0, valid1}, 64'd0);
            if (!valid1) check_eq("data_empty", {32'd0, data1}, 64'd0);
            if (prev_stall) begin
                check_eq("hold_valid", {63'd0, valid1}, 64'd1);
                check_eq("hold_data", {32'd0, data1}, {32'd0, prev_data});
            end
            prev_stall = valid1 && !m_ready_i;
            prev_data  = data1;
            if (valid1 && first_valid < 0) first_valid = j;
            if (pop) begin
                got.push_back(data1);
                accepted++;
                if (accepted == n) last_acc = j;
            end
            if (valid2 && m_ready_i) beats2.push_back(data2);
            if (rst_after > 0 && accepted == rst_after) begin
                reset_n = 1'b0;
                #1;
                check_reset_outputs("midrun");
                repeat (2) @(negedge clk);
                reset_n = 1'b1;
                aborted  = 1'b1;
                finished = 1'b1;
            end
            if (exp_idle) finished = 1'b1;
            if (j > 400 + 4 * n) begin
                check_eq("timeout", 64'(j), 64'(400 + 4 * n));
                finished = 1'b1;
                aborted  = 1'b1;
            end
        end

        if (!aborted) begin
            check_eq("beat_count", 64'(got.size()), 64'(n));
            for (int i = 0; i < got.size() && i < n; i++)
                check_eq("beat_data", {32'd0, got[i]}, {32'd0, mem1[i % 256]});
            check_eq("aw2_addr_count", 64'(addrs2.size()), 64'(n));
            for (int i = 0; i < addrs2.size() && i < n; i++)
                check_eq("aw2_addr", {62'd0, addrs2[i]}, 64'(i % 4));
            check_eq("aw2_beat_count", 64'(beats2.size()), 64'(n));
            for (int i = 0; i < beats2.size() && i < n; i++)
                check_eq("aw2_beat_data", {32'd0, beats2[i]}, {32'd0, mem2[i % 4]});
            if (chk_lat) begin
                check_eq("first_valid_cycle", 64'(first_valid), 64'd2);
                // edges counted from E0 through the edge that accepts the last beat
                check_eq("edges_to_last_beat", 64'(last_acc + 2), 64'(n + 3));
            end
        end

        if (hold_start) begin
            @(negedge clk);
            #1;
            check_eq("restart_after_idle", {63'd0, run1}, 64'd1);
            pulse_reset();
        end
        start_run_i = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        start_run_i = 1'b0;
        run_count_i = '0;
        m_ready_i   = 1'b0;
        for (int i = 0; i < 256; i++) mem1[i] = $urandom;
        for (int i = 0; i < 4; i++) begin
            mem1[i] = 32'hA0 + 32'(i);
            mem2[i] = $urandom;
        end
        #1;
        check_reset_outputs("por");
        check_eq("we_tied", {63'd0, we1}, 64'd0);
        check_eq("d_tied", {32'd0, d1}, 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        do_run(4, 0, 1'b0, 0, 1'b1);
        do_run(0, 0, 1'b0, 0, 1'b0);
        do_run(6, 1, 1'b0, 0, 1'b0);
        do_run(6, 0, 1'b0, 2, 1'b0);
        do_run(3, 0, 1'b0, 0, 1'b0);
        do_run(5, 0, 1'b1, 0, 1'b0);
        for (int k = 0; k < 8; k++) do_run($urandom_range(0, 12), 2, 1'b0, 0, 1'b0);
        do_run(300, 2, 1'b0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
